// File: rtl/silife_grid_reader_if.sv
// Grid row read port plus the outbound row-byte stream of the grid reader.
// The master side is the reader. The slave side is the grid together with the consumer.
interface silife_grid_reader_if;
  logic       en;
  logic       start;
  logic [4:0] row_select;
  logic [7:0] cells;
  logic       rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    input  en, start, cells, out_ready,
    output row_select, rd_en, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output en, start, cells, out_ready,
    input  row_select, rd_en, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/silife_grid_reader.sv
// Scans the Life grid row by row on a start pulse.
// Each row leaves as one bit-reversed byte on a valid/ready stream.
module silife_grid_reader #(
  parameter int ROWS         = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  silife_grid_reader_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [7:0] data_q, data_d;

  // cells[0] is the leftmost cell, so it becomes the MSB of the output byte.
  function automatic logic [7:0] bit_reverse(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.en) begin
          state_d = FETCH;
          row_d   = '0;
        end
      end
      FETCH: begin
        if (bus.en) begin
          if (READ_LATENCY == 0) begin
            data_d  = bit_reverse(bus.cells);
            state_d = PRESENT;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.en) begin
          data_d  = bit_reverse(bus.cells);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // The handshake completes regardless of en; only the next fetch waits.
        if (bus.out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = DONE;
            row_d   = '0;
          end else begin
            state_d = FETCH;
            row_d   = row_q + 5'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      data_q  <= data_d;
    end
  end

  assign bus.row_select = row_q;
  assign bus.rd_en      = (state_q == FETCH) || (state_q == WAIT);
  assign bus.out_data   = data_q;
  assign bus.out_valid  = (state_q == PRESENT);
  assign bus.out_last   = (state_q == PRESENT) && (row_q == LAST_ROW);
  assign bus.busy       = (state_q == FETCH) || (state_q == WAIT) || (state_q == PRESENT);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_silife_grid_reader.sv
// Directed bench for silife_grid_reader: READ_LATENCY=1 instance for most scenarios,
// plus a READ_LATENCY=0 instance for the fast-read timing scenario.
module tb_silife_grid_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  silife_grid_reader_if bus ();
  silife_grid_reader_if bus0 ();

  silife_grid_reader #(.ROWS(32), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  silife_grid_reader #(.ROWS(32), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.master)
  );

  // Grid model: one-cycle registered read port and a combinational read port.
  logic [7:0] grid [0:31];
  always @(posedge clk) bus.cells <= grid[bus.row_select];
  assign bus0.cells = grid[bus0.row_select];

  int checks = 0;
  int errors = 0;

  // Observations collected by run_frame.
  logic [7:0] got_data [0:63];
  logic       got_last [0:63];
  int         got_cyc  [0:63];
  int         n_bytes, n_done, done_cyc;
  logic       done_busy;
  logic [4:0] k1_sel;
  logic       k1_rd;
  logic       stl_valid [0:7];
  logic [7:0] stl_data  [0:7];
  logic [4:0] stl_row   [0:7];
  int         n_stl;
  logic [6:0] frz_smp [0:7];
  int         n_frz;

  task automatic run_frame(input int stall_row, input int stall_len,
                           input int freeze_row, input int freeze_len,
                           input int start_row);
    int  stl_cnt, seen, frz_left, post;
    bit  start_sent, frz_started;
    for (int i = 0; i < 64; i++) begin
      got_data[i] = 'x; got_last[i] = 1'bx; got_cyc[i] = -1;
    end
    n_bytes = 0; n_done = 0; done_cyc = -1; n_stl = 0; n_frz = 0; done_busy = 1'bx;
    stl_cnt = 0; seen = 0; frz_left = 0; post = 0; start_sent = 0; frz_started = 0;
    bus.en = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 1) begin k1_sel = bus.row_select; k1_rd = bus.rd_en; end
      if (bus.done) begin n_done++; done_cyc = k; done_busy = bus.busy; end
      if (stall_row >= 0 && n_bytes == stall_row && stl_cnt < stall_len &&
          (bus.out_valid || stl_cnt > 0)) begin
        if (n_stl < 8) begin
          stl_valid[n_stl] = bus.out_valid;
          stl_data[n_stl]  = bus.out_data;
          stl_row[n_stl]   = bus.row_select;
        end
        n_stl++;
        if (stl_cnt == 0) grid[stall_row] = ~grid[stall_row];
        stl_cnt++;
        bus.out_ready = 1'b0;
      end else if (bus.out_valid) begin
        bus.out_ready = 1'b1;
        if (n_bytes < 64) begin
          got_data[n_bytes] = bus.out_data;
          got_last[n_bytes] = bus.out_last;
          got_cyc[n_bytes]  = k;
        end
        n_bytes++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (frz_left > 0) begin
        if (n_frz < 8) frz_smp[n_frz] = {bus.rd_en, bus.row_select, bus.out_valid};
        n_frz++;
        frz_left--;
        if (frz_left == 0) bus.en = 1'b1;
      end else if (freeze_row >= 0 && freeze_len > 0 && !frz_started &&
                   bus.rd_en && bus.row_select == 5'(freeze_row)) begin
        seen++;
        if (seen == 2) begin
          bus.en = 1'b0; frz_left = freeze_len; frz_started = 1'b1;
        end
      end
      if (start_row >= 0 && !start_sent && bus.rd_en && bus.row_select == 5'(start_row)) begin
        bus.start = 1'b1; start_sent = 1'b1;
      end
      if (n_done > 0) post++;
      if (post >= 5) break;
    end
    bus.start = 1'b0; bus.out_ready = 1'b1; bus.en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.row_select, bus.rd_en, bus.out_data, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {bus.row_select, bus.rd_en, bus.out_data, bus.out_valid, bus.out_last, bus.busy, bus.done});
    end
    checks++;
    if ({bus0.row_select, bus0.rd_en, bus0.out_data, bus0.out_valid, bus0.out_last, bus0.busy, bus0.done} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs_lat0 got %h want 0",
               {bus0.row_select, bus0.rd_en, bus0.out_data, bus0.out_valid, bus0.out_last, bus0.busy, bus0.done});
    end
    rst_n = 1'b1;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.rd_en} !== 2'b00) begin
      errors++;
      $display("FAIL idle_without_start got %b want 00", {bus.busy, bus.rd_en});
    end
  endtask

  task automatic test_frame();
    int nlast;
    for (int r = 0; r < 32; r++) grid[r] = 8'(8'h01 << (r % 8));
    run_frame(-1, 0, -1, 0, -1);
    checks++;
    if ({k1_sel, k1_rd} !== {5'd0, 1'b1}) begin
      errors++; $display("FAIL frame_first_fetch got %h want %h", {k1_sel, k1_rd}, {5'd0, 1'b1});
    end
    checks++;
    if (n_bytes !== 32) begin errors++; $display("FAIL frame_count got %0d want 32", n_bytes); end
    nlast = 0;
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (got_data[r] !== 8'(8'h80 >> (r % 8))) begin
        errors++; $display("FAIL frame_byte%0d got %h want %h", r, got_data[r], 8'(8'h80 >> (r % 8)));
      end
      checks++;
      if (got_cyc[r] !== 3 + 3 * r) begin
        errors++; $display("FAIL frame_cycle%0d got %0d want %0d", r, got_cyc[r], 3 + 3 * r);
      end
      if (got_last[r] === 1'b1) nlast++;
    end
    checks++;
    if (got_last[31] !== 1'b1 || nlast !== 1) begin
      errors++; $display("FAIL frame_last got last31=%b count=%0d want 1 and 1", got_last[31], nlast);
    end
    checks++;
    if (n_done !== 1 || done_cyc !== 97) begin
      errors++; $display("FAIL frame_done got n=%0d cyc=%0d want n=1 cyc=97", n_done, done_cyc);
    end
    checks++;
    if (done_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_at_done got %b want 0", done_busy); end
  endtask

  task automatic test_round_trip();
    logic [7:0] pat [0:7];
    logic [7:0] ld  [0:7];
    pat = '{8'h01, 8'hC0, 8'h12, 8'hF0, 8'h35, 8'h0E, 8'h9B, 8'h47};
    ld  = '{8'h80, 8'h03, 8'h48, 8'h0F, 8'hAC, 8'h70, 8'hD9, 8'hE2};
    for (int r = 0; r < 32; r++) grid[r] = ld[(r + r / 8) % 8];
    run_frame(-1, 0, -1, 0, -1);
    checks++;
    if (n_bytes !== 32) begin errors++; $display("FAIL rt_count got %0d want 32", n_bytes); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (got_data[r] !== pat[(r + r / 8) % 8]) begin
        errors++; $display("FAIL rt_byte%0d got %h want %h", r, got_data[r], pat[(r + r / 8) % 8]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] expb [0:31];
    logic [7:0] b;
    for (int r = 0; r < 32; r++) begin
      b = {3'b000, 5'(r)};
      grid[r] = b;
      expb[r] = {<<{b}};
    end
    run_frame(3, 5, -1, 0, -1);
    checks++;
    if (n_stl !== 5) begin errors++; $display("FAIL bp_stall_count got %0d want 5", n_stl); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({stl_valid[i], stl_data[i], stl_row[i]} !== {1'b1, 8'hC0, 5'd3}) begin
        errors++;
        $display("FAIL bp_hold%0d got %h want %h", i, {stl_valid[i], stl_data[i], stl_row[i]}, {1'b1, 8'hC0, 5'd3});
      end
    end
    checks++;
    if (n_bytes !== 32) begin errors++; $display("FAIL bp_count got %0d want 32", n_bytes); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (got_data[r] !== expb[r]) begin
        errors++; $display("FAIL bp_byte%0d got %h want %h", r, got_data[r], expb[r]);
      end
    end
    checks++;
    if (n_done !== 1 || done_cyc !== 102) begin
      errors++; $display("FAIL bp_done got n=%0d cyc=%0d want n=1 cyc=102", n_done, done_cyc);
    end
  endtask

  task automatic test_en_freeze();
    logic [7:0] b;
    for (int r = 0; r < 32; r++) grid[r] = {3'b000, 5'(r)};
    run_frame(-1, 0, 10, 4, -1);
    checks++;
    if (n_frz !== 4) begin errors++; $display("FAIL frz_count got %0d want 4", n_frz); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (frz_smp[i] !== {1'b1, 5'd10, 1'b0}) begin
        errors++; $display("FAIL frz_hold%0d got %h want %h", i, frz_smp[i], {1'b1, 5'd10, 1'b0});
      end
    end
    checks++;
    if (got_cyc[10] !== 37) begin errors++; $display("FAIL frz_capture_cycle got %0d want 37", got_cyc[10]); end
    for (int r = 0; r < 32; r++) begin
      b = {3'b000, 5'(r)};
      checks++;
      if (got_data[r] !== {<<{b}}) begin
        errors++; $display("FAIL frz_byte%0d got %h want %h", r, got_data[r], {<<{b}});
      end
    end
    checks++;
    if (n_bytes !== 32 || n_done !== 1 || done_cyc !== 101) begin
      errors++; $display("FAIL frz_done got bytes=%0d n=%0d cyc=%0d want 32 1 101", n_bytes, n_done, done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    for (int r = 0; r < 32; r++) grid[r] = 8'(8'h01 << (r % 8));
    run_frame(-1, 0, -1, 0, 5);
    checks++;
    if (n_bytes !== 32 || n_done !== 1 || done_cyc !== 97) begin
      errors++; $display("FAIL start_ignored got bytes=%0d n=%0d cyc=%0d want 32 1 97", n_bytes, n_done, done_cyc);
    end
    checks++;
    if (got_data[6] !== 8'h02) begin errors++; $display("FAIL start_ignored_byte6 got %h want 02", got_data[6]); end
  endtask

  task automatic test_reset_mid();
    bit found;
    for (int r = 0; r < 32; r++) grid[r] = {3'b000, 5'(r)};
    found = 1'b0;
    bus.en = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.out_valid && bus.row_select == 5'd12) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1 || bus.out_data !== 8'h30) begin
      errors++; $display("FAIL rstmid_reach_row12 got found=%b data=%h want 1 30", found, bus.out_data);
    end
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.row_select, bus.rd_en, bus.out_data, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 18'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h want 0",
               {bus.row_select, bus.rd_en, bus.out_data, bus.out_valid, bus.out_last, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.rd_en, bus.out_valid, bus.done} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_idle got %b want 0000", {bus.busy, bus.rd_en, bus.out_valid, bus.done});
    end
  endtask

  task automatic test_lat0();
    int nb, nd, dc, fv, post;
    bit cyc_ok, data_ok;
    for (int r = 0; r < 32; r++) grid[r] = 8'(8'h01 << (r % 8));
    nb = 0; nd = 0; dc = -1; fv = -1; post = 0; cyc_ok = 1'b1; data_ok = 1'b1;
    bus0.en = 1'b1; bus0.out_ready = 1'b1;
    @(negedge clk);
    bus0.start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      if (bus0.done) begin nd++; dc = k; end
      if (bus0.out_valid) begin
        if (fv < 0) fv = k;
        if (k != 2 + 2 * nb) cyc_ok = 1'b0;
        if (bus0.out_data !== 8'(8'h80 >> (nb % 8))) data_ok = 1'b0;
        nb++;
      end
      if (nd > 0) post++;
      if (post >= 4) break;
    end
    checks++;
    if (fv !== 2) begin errors++; $display("FAIL lat0_first_valid got %0d want 2", fv); end
    checks++;
    if (nb !== 32 || cyc_ok !== 1'b1) begin
      errors++; $display("FAIL lat0_rate got bytes=%0d on_schedule=%b want 32 1", nb, cyc_ok);
    end
    checks++;
    if (data_ok !== 1'b1) begin errors++; $display("FAIL lat0_data got ok=%b want 1", data_ok); end
    checks++;
    if (nd !== 1 || dc !== 65) begin
      errors++; $display("FAIL lat0_done got n=%0d cyc=%0d want n=1 cyc=65", nd, dc);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) grid[r] = 8'h00;
    bus.en = 1'b0;  bus.start = 1'b0;  bus.out_ready = 1'b1;
    bus0.en = 1'b0; bus0.start = 1'b0; bus0.out_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_en_freeze();
    test_start_ignored();
    test_reset_mid();
    test_round_trip();
    test_lat0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
